fma_sequencer: RTL and testbench

Multi-cycle sequencer for the four fused-form ops: fmadd, fmsub, fnmadd and fnmsub. It time-shares one fmul and one fadd instance across them. Operands arrive on a valid/ready handshake, and the product is registered between the multiply and add phases. The result is held on a valid/ready output. It sits between the issue logic and the shared FP arithmetic units, and replaces the per-op fused wrappers.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fadd.sv | 97 +++++++++
 rtl/fmul.sv | 69 ++++++
 rtl/fma_sequencer.sv | 116 +++++++++++
 tb/tb_fma_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the fused multiply-add sequencer
// and the single-precision arithmetic units it drives.
package fpu_pkg;

  localparam int FP32_SIGN = 31;
  localparam logic [31:0] FP32_QNAN = 32'h7fc0_0000;

  typedef enum logic [1:0] {
    FMADD  = 2'd0,
    FMSUB  = 2'd1,
    FNMSUB = 2'd2,
    FNMADD = 2'd3
  } fma_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  function automatic logic neg_prod(fma_op_e op);
    return (op == FNMSUB) || (op == FNMADD);
  endfunction

  function automatic logic neg_c(fma_op_e op);
    return (op == FMSUB) || (op == FNMADD);
  endfunction

endpackage

// File: rtl/fadd.sv
// Combinational FP32 add, round-to-nearest-even.
// Subnormal inputs and results flush to zero.
module fadd
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic [31:0] x, w;
  logic        sx;
  logic [7:0]  ex, ew, d;
  logic [26:0] mx, mw, mw_s, mask;
  logic        stk, eff_sub;
  logic [27:0] s;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic [23:0] m;
  logic        g, st, inc;
  logic [24:0] mr;
  logic [22:0] frac;
  logic        a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    a_inf = (a_i[30:23] == 8'hff) && (a_i[22:0] == '0);
    b_inf = (b_i[30:23] == 8'hff) && (b_i[22:0] == '0);
    a_nan = (a_i[30:23] == 8'hff) && (a_i[22:0] != '0);
    b_nan = (b_i[30:23] == 8'hff) && (b_i[22:0] != '0);
    if (a_i[30:0] >= b_i[30:0]) begin
      x = a_i;
      w = b_i;
    end else begin
      x = b_i;
      w = a_i;
    end
    sx = x[31];
    ex = x[30:23];
    ew = w[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    mw = (ew == 8'd0) ? 27'd0
                      : {1'b1, w[22:0], 3'b000};
    d  = ex - ew;
    mask = '0;
    // Aligned operand keeps a sticky bit for correct rounding
    if (d >= 8'd27) begin
      stk  = |mw;
      mw_s = {26'd0, stk};
    end else begin
      mask = (27'd1 << d) - 27'd1;
      stk  = |(mw & mask);
      mw_s = (mw >> d) | {26'd0, stk};
    end
    eff_sub = x[31] ^ w[31];
    s = eff_sub ? ({1'b0, mx} - {1'b0, mw_s})
                : ({1'b0, mx} + {1'b0, mw_s});
    e  = {2'b0, ex};
    lz = '0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 0; i < 27; i++)
        if (s[i]) lz = 5'(26 - i);
      s = s << lz;
      e = e - {5'd0, lz};
    end
    m  = s[26:3];
    g  = s[2];
    st = |s[1:0];
    inc = g & (st | m[0]);
    mr  = {1'b0, m} + {24'd0, inc};
    frac = mr[22:0];
    if (mr[24]) begin
      e    = e + 10'd1;
      frac = mr[23:1];
    end
    if (a_nan || b_nan
        || (a_inf && b_inf && (a_i[31] != b_i[31])))
      y_o = FP32_QNAN;
    else if (a_inf)
      y_o = a_i;
    else if (b_inf)
      y_o = b_i;
    else if (ex == 8'd0)
      y_o = {a_i[31] & b_i[31], 31'd0};
    else if (s == 28'd0)
      y_o = 32'd0;
    else if ($signed(e) >= 10'sd255)
      y_o = {sx, 8'hff, 23'd0};
    else if ($signed(e) <= 10'sd0)
      y_o = {sx, 31'd0};
    else
      y_o = {sx, e[7:0], frac};
  end

endmodule

// File: rtl/fmul.sv
// Combinational FP32 multiply, round-to-nearest-even.
// Subnormal inputs and results flush to zero.
module fmul
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  logic        sy;
  logic [7:0]  ea, eb;
  logic [47:0] p;
  logic [9:0]  e;
  logic [23:0] m;
  logic        g, st, inc;
  logic [24:0] mr;
  logic [22:0] frac;
  logic        a_zero, b_zero;
  logic        a_inf, b_inf;
  logic        a_nan, b_nan;

  always_comb begin
    sy = a_i[31] ^ b_i[31];
    ea = a_i[30:23];
    eb = b_i[30:23];
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf = (ea == 8'hff) && (a_i[22:0] == '0);
    b_inf = (eb == 8'hff) && (b_i[22:0] == '0);
    a_nan = (ea == 8'hff) && (a_i[22:0] != '0);
    b_nan = (eb == 8'hff) && (b_i[22:0] != '0);
    p = {24'd0, 1'b1, a_i[22:0]}
      * {24'd0, 1'b1, b_i[22:0]};
    e = {2'b0, ea} + {2'b0, eb} - 10'd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    inc = g & (st | m[0]);
    mr  = {1'b0, m} + {24'd0, inc};
    frac = mr[22:0];
    // Rounding carry-out leaves 1.0 with a zero fraction
    if (mr[24]) begin
      e    = e + 10'd1;
      frac = mr[23:1];
    end
    if (a_nan || b_nan || (a_inf && b_zero)
        || (b_inf && a_zero))
      y_o = FP32_QNAN;
    else if (a_inf || b_inf)
      y_o = {sy, 8'hff, 23'd0};
    else if (a_zero || b_zero)
      y_o = {sy, 31'd0};
    else if ($signed(e) >= 10'sd255)
      y_o = {sy, 8'hff, 23'd0};
    else if ($signed(e) <= 10'sd0)
      y_o = {sy, 31'd0};
    else
      y_o = {sy, e[7:0], frac};
  end

endmodule

// File: rtl/fma_sequencer.sv
// Sequences fmadd/fmsub/fnmadd/fnmsub over one shared
// fmul and one shared fadd: IDLE -> MUL -> ADD -> DONE.
module fma_sequencer
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [31:0]      var1,
  input  logic [31:0]      var2,
  input  logic [31:0]      var3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  fma_op_e          op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      c_q, c_d;
  logic [31:0]      prod_q, prod_d;
  logic [31:0]      res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic [31:0]      mul_y, add_y;

  fmul u_fmul (
    .a_i (a_q),
    .b_i (b_q),
    .y_o (mul_y)
  );

  fadd u_fadd (
    .a_i (prod_q),
    .b_i (c_q),
    .y_o (add_y)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    prod_d  = prod_q;
    res_d   = res_q;
    tag_d   = tag_q;
    otag_d  = otag_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = fma_op_e'(op);
          a_d   = var1;
          b_d   = var2;
          c_d   = {var3[FP32_SIGN] ^ neg_c(fma_op_e'(op)),
                   var3[FP32_SIGN-1:0]};
          tag_d = in_tag;
          state_d = MUL;
        end
      end
      MUL: begin
        prod_d = {mul_y[FP32_SIGN] ^ neg_prod(op_q),
                  mul_y[FP32_SIGN-1:0]};
        state_d = ADD;
      end
      ADD: begin
        res_d   = add_y;
        otag_d  = tag_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= FMADD;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      otag_q  <= otag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = res_q;
  assign out_tag   = otag_q;

endmodule

// File: tb/tb_fma_sequencer.sv
// Directed bench for fma_sequencer with a result
// scoreboard checked by immediate assertions.
module tb_fma_sequencer;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] var1, var2, var3;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [3:0]  out_tag;
  logic        busy;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  localparam logic [31:0] A2 = 32'h4000_0000;
  localparam logic [31:0] B3 = 32'h4040_0000;
  localparam logic [31:0] C1 = 32'h3f80_0000;

  fma_sequencer #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .var1      (var1),
    .var2      (var2),
    .var3      (var3),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] c,
                       input logic [3:0] t);
    op = o; var1 = a; var2 = b; var3 = c; in_tag = t;
  endtask

  // Accept one request; on return the DUT is in MUL
  task automatic send(input string tag,
                      input logic [1:0] o,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] c,
                      input logic [3:0] t);
    int k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    drive(o, a, b, c, t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_res"}, res, e.res);
      chk({tag, "_tag"}, {28'd0, out_tag}, {28'd0, e.tag});
    end
  endtask

  task automatic one_op(input string tag,
                        input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] c,
                        input logic [3:0] t,
                        input logic [31:0] r);
    int lat;
    sb.push_back('{res: r, tag: t});
    send(tag, o, a, b, c, t);
    wait_out(lat);
    chk({tag, "_lat"}, lat, 32'd2);
    pop_chk(tag);
    tick();
    chk({tag, "_release"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat, n, bad;
    logic [31:0] held;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    one_op("fmadd", 2'd0, A2, B3, C1, 4'd1, 32'h40e0_0000);
    one_op("fmsub", 2'd1, A2, B3, C1, 4'd2, 32'h40a0_0000);
    one_op("fnmsub", 2'd2, A2, B3, C1, 4'd4, 32'hc0a0_0000);
    one_op("fnmadd", 2'd3, A2, B3, C1, 4'd6, 32'hc0e0_0000);
    one_op("neg_b_add", 2'd0, 32'h3fc0_0000, 32'hc000_0000,
           32'h3f00_0000, 4'd7, 32'hc020_0000);
    one_op("neg_b_sub", 2'd1, 32'h3fc0_0000, 32'hc000_0000,
           32'h3f00_0000, 4'd8, 32'hc060_0000);

    // Backpressure
    out_ready = 1'b0;
    sb.push_back('{res: 32'h40e0_0000, tag: 4'd9});
    send("bp", 2'd0, A2, B3, C1, 4'd9);
    wait_out(lat);
    chk("bp_lat", lat, 32'd2);
    held = res;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || res !== held || in_ready) bad++;
      tick();
    end
    chk("bp_hold", bad, 32'd0);
    pop_chk("bp");
    out_ready = 1'b1;
    tick();
    chk("bp_idle", {31'd0, busy}, 32'd0);
    chk("bp_drop", {31'd0, out_valid}, 32'd0);

    // Back-to-back with in_valid held high
    sb.push_back('{res: 32'h40e0_0000, tag: 4'd3});
    drive(2'd0, A2, B3, C1, 4'd3);
    in_valid = 1'b1;
    tick();
    drive(2'd3, A2, B3, C1, 4'd5);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    pop_chk("b2b_first");
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    sb.push_back('{res: 32'hc0e0_0000, tag: 4'd5});
    tick();
    n++;
    in_valid = 1'b0;
    chk("b2b_interval", n, 32'd4);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_out(lat);
    chk("b2b_lat", lat, 32'd2);
    pop_chk("b2b_second");
    tick();

    // Reset during ADD discards the request
    send("rst_mid", 2'd0, A2, B3, C1, 4'd10);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("rstmid_ready", {31'd0, in_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) bad++;
      tick();
    end
    chk("rstmid_no_stale", bad, 32'd0);

    // Operand change after accept has no effect
    sb.push_back('{res: 32'h40e0_0000, tag: 4'd12});
    send("opchg", 2'd0, A2, B3, C1, 4'd12);
    var1 = 32'h4120_0000;
    wait_out(lat);
    chk("opchg_lat", lat, 32'd2);
    pop_chk("opchg");
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
